// File: rtl/master_stream_pkg.sv
// rtl/master_stream_pkg.sv - shared types and helpers for the serial streaming master
package master_stream_pkg;

  typedef enum logic [1:0] {IDLE, ARM, WAIT, SHIFT} state_t;

  localparam int MAX_W = 64;

  function automatic int calc_s(input int data_w, input int lanes);
    return data_w / lanes;
  endfunction

  // Symbol index at which the next word must be requested so it lands on the boundary
  function automatic int calc_pf(input int s, input int rd_lat);
    return s - 2 - rd_lat;
  endfunction

  function automatic int calc_blk_w(input int blocksize);
    return $clog2(blocksize) + 1;
  endfunction

  function automatic logic [MAX_W-1:0] sym_sel(input logic [MAX_W-1:0] word, input int j,
                                               input bit msb_first, input int data_w,
                                               input int lanes);
    logic [MAX_W-1:0] mask;
    mask = (64'd1 << lanes) - 64'd1;
    if (msb_first)
      return (word >> (data_w - (j + 1) * lanes)) & mask;
    else
      return (word >> (j * lanes)) & mask;
  endfunction

endpackage

// File: rtl/master_stream_if_serializer.sv
// rtl/master_stream_if_serializer.sv - shift register, symbol counter and miso register
module msif_serializer
  import master_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int RD_LAT    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic [LANES-1:0]  miso,
  output logic              at_prefetch,
  output logic              at_boundary
);

  localparam int S    = calc_s(DATA_W, LANES);
  localparam int PF   = calc_pf(S, RD_LAT);
  localparam int SC_W = $clog2(S);

  logic [DATA_W-1:0] shreg;
  logic [SC_W-1:0]   symcnt;
  logic [LANES-1:0]  sym_load;
  logic [LANES-1:0]  sym_next;

  always_comb begin
    sym_load = LANES'(sym_sel(MAX_W'(data), 0, MSB_FIRST != 0, DATA_W, LANES));
    sym_next = LANES'(sym_sel(MAX_W'(shreg), int'(symcnt) + 1, MSB_FIRST != 0, DATA_W, LANES));
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      shreg  <= '0;
      symcnt <= '0;
      miso   <= '0;
    end else if (load) begin
      shreg  <= data;
      symcnt <= '0;
      miso   <= sym_load;
    end else if (clear) begin
      symcnt <= '0;
      miso   <= '0;
    end else if (shift) begin
      symcnt <= symcnt + 1'b1;
      miso   <= sym_next;
    end
  end

  assign at_prefetch = (symcnt == SC_W'(PF));
  assign at_boundary = (symcnt == SC_W'(S - 1));

endmodule

// File: rtl/master_stream_if.sv
// rtl/master_stream_if.sv - host-facing serial streaming master draining a read-side FIFO
module master_stream_if
  import master_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int CNT_W     = 10,
  parameter int BLOCKSIZE = 1024,
  parameter int RD_LAT    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [CNT_W-1:0]  wrcnt,
  input  logic              mosi,
  output logic              fifo_rd,
  output logic              fifo_clr,
  input  logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  miso,
  output logic              busy,
  output logic              underrun,
  output logic              blk_done
);

  localparam int S     = calc_s(DATA_W, LANES);
  localparam int BLK_W = calc_blk_w(BLOCKSIZE);

  if (S * LANES != DATA_W) begin : g_chk_lanes
    $fatal(1, "master_stream_if: LANES must divide DATA_W");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_chk_lat
    $fatal(1, "master_stream_if: RD_LAT must be 1 or 2");
  end
  if (S < RD_LAT + 2) begin : g_chk_s
    $fatal(1, "master_stream_if: symbols per word must be at least RD_LAT+2");
  end
  if (DATA_W > MAX_W) begin : g_chk_w
    $fatal(1, "master_stream_if: DATA_W too wide");
  end

  state_t           state, state_nxt;
  logic [1:0]       waitcnt, waitcnt_nxt;
  logic [BLK_W-1:0] blkcnt, blkcnt_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             last, last_nxt;
  logic             und_nxt, fifo_rd_nxt, fifo_clr_nxt, done_nxt, busy_nxt;
  logic             ser_load, ser_shift, ser_clear;
  logic             at_prefetch, at_boundary;

  msif_serializer #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .RD_LAT   (RD_LAT),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk        (clk),
    .arstn      (arstn),
    .load       (ser_load),
    .shift      (ser_shift),
    .clear      (ser_clear),
    .data       (rdata),
    .miso       (miso),
    .at_prefetch(at_prefetch),
    .at_boundary(at_boundary)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      waitcnt  <= '0;
      blkcnt   <= '0;
      rd_pend  <= 1'b0;
      last     <= 1'b0;
      underrun <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_clr <= 1'b0;
      blk_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      waitcnt  <= waitcnt_nxt;
      blkcnt   <= blkcnt_nxt;
      rd_pend  <= rd_pend_nxt;
      last     <= last_nxt;
      underrun <= und_nxt;
      fifo_rd  <= fifo_rd_nxt;
      fifo_clr <= fifo_clr_nxt;
      blk_done <= done_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    waitcnt_nxt  = waitcnt;
    blkcnt_nxt   = blkcnt;
    rd_pend_nxt  = rd_pend;
    last_nxt     = last;
    und_nxt      = underrun;
    fifo_rd_nxt  = 1'b0;
    fifo_clr_nxt = 1'b0;
    done_nxt     = 1'b0;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_clear    = 1'b0;
    case (state)
      IDLE: begin
        ser_clear = 1'b1;
        if (!mosi) state_nxt = ARM;
      end
      ARM: begin
        ser_clear = 1'b1;
        if (mosi) begin
          fifo_clr_nxt = 1'b1;
          und_nxt      = 1'b0;
          state_nxt    = IDLE;
        end else if (wrcnt == '0) begin
          und_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          fifo_rd_nxt = 1'b1;
          und_nxt     = 1'b0;
          blkcnt_nxt  = '0;
          waitcnt_nxt = '0;
          last_nxt    = 1'b0;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (waitcnt == 2'(RD_LAT)) begin
          ser_load    = 1'b1;
          rd_pend_nxt = 1'b0;
          state_nxt   = SHIFT;
        end else begin
          ser_clear   = 1'b1;
          waitcnt_nxt = waitcnt + 2'd1;
        end
      end
      SHIFT: begin
        if (at_boundary) begin
          if (rd_pend) begin
            ser_load    = 1'b1;
            rd_pend_nxt = 1'b0;
            blkcnt_nxt  = blkcnt + 1'b1;
          end else begin
            // Either the block is complete or the host/FIFO asked us to stop
            ser_clear = 1'b1;
            done_nxt  = last;
            state_nxt = IDLE;
          end
        end else begin
          ser_shift = 1'b1;
          if (at_prefetch) begin
            if (blkcnt == BLK_W'(BLOCKSIZE - 1)) begin
              last_nxt = 1'b1;
            end else if (mosi) begin
              last_nxt = 1'b0;
            end else if (wrcnt == '0) begin
              und_nxt = 1'b1;
            end else begin
              fifo_rd_nxt = 1'b1;
              rd_pend_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == WAIT) || (state_nxt == SHIFT);
  end

endmodule
